// File: rtl/swir_pll_reset_ctrl.sv
// SWIR PLL reset / lock supervisor.
// Pulses the PLL reset, waits for lock, requires the lock to stay up for a
// programmed time before releasing downstream logic, and re-sequences on lock
// loss or lock timeout. After MAX_RETRIES+1 failed attempts it parks in FAULT
// until restart or rst.
module swir_pll_reset_ctrl #(
    parameter int RST_PULSE_CYCLES    = 50,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16,
    parameter int RETRY_W             = 4
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               restart,
    output logic               pll_rst,
    output logic               sys_rst,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_count,
    output logic [7:0]         lock_loss_count
);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic [7:0]         loss_nxt;
    logic               sync1, locked_s;

    // Two-flop synchroniser for the asynchronous PLL lock indication
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= pll_locked;
            locked_s <= sync1;
        end
    end

    // Next-state, counter and statistics logic; restart overrides everything
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        loss_nxt  = lock_loss_count;
        cnt_nxt   = cnt;
        if (restart) begin
            state_nxt = RESET_PLL;
            retry_nxt = '0;
        end else begin
            case (state)
                RESET_PLL: begin
                    if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_count == RETRY_MAX) begin
                            state_nxt = FAULT;
                        end else begin
                            retry_nxt = retry_count + 1'b1;
                            state_nxt = RESET_PLL;
                        end
                    end
                end
                STABLE: begin
                    // Lock loss takes precedence over stable-time completion
                    if (!locked_s)                state_nxt = WAIT_LOCK;
                    else if (cnt == STABLE_LAST)  state_nxt = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        loss_nxt  = (lock_loss_count == 8'hFF) ? lock_loss_count
                                                               : lock_loss_count + 8'd1;
                        retry_nxt = '0;
                        state_nxt = RESET_PLL;
                    end
                end
                FAULT: state_nxt = FAULT;
                default: state_nxt = RESET_PLL;
            endcase
        end
        // cnt restarts on any state change (and on restart, even from RESET_PLL);
        // it only advances in the timed states so it can never wrap.
        if (restart || state_nxt != state)
            cnt_nxt = '0;
        else if (state == RESET_PLL || state == WAIT_LOCK || state == STABLE)
            cnt_nxt = cnt + 1'b1;
    end

    // State, counter and statistics registers
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state           <= RESET_PLL;
            cnt             <= '0;
            retry_count     <= '0;
            lock_loss_count <= '0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            retry_count     <= retry_nxt;
            lock_loss_count <= loss_nxt;
        end
    end

    // Registered outputs decoded from the state being entered at this edge
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            pll_rst <= 1'b1;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
            fault   <= 1'b0;
        end else begin
            pll_rst <= (state_nxt == RESET_PLL) || (state_nxt == FAULT);
            sys_rst <= (state_nxt != RUN);
            ready   <= (state_nxt == RUN);
            fault   <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_swir_pll_reset_ctrl.sv
// Scoreboard bench for swir_pll_reset_ctrl with RST_PULSE=4, TIMEOUT=20,
// STABLE=8, MAX_RETRIES=2. Expected output vectors are queued with the edge
// number at which they must appear and compared #1 after that edge.
// Vector layout: {pll_rst, sys_rst, ready, fault, retry_count[3:0], lock_loss_count[7:0]}.
module tb_swir_pll_reset_ctrl;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, sys_rst, ready, fault;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    swir_pll_reset_ctrl #(
        .RST_PULSE_CYCLES(4), .LOCK_TIMEOUT_CYCLES(20), .LOCK_STABLE_CYCLES(8),
        .MAX_RETRIES(2), .CNT_W(16), .RETRY_W(4)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
        .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
        .retry_count(retry_count), .lock_loss_count(lock_loss_count)
    );

    always #10 refclk = ~refclk;

    function automatic logic [15:0] obs();
        return {pll_rst, sys_rst, ready, fault, retry_count, lock_loss_count};
    endfunction

    task automatic push(input int c, input logic [15:0] v, input string n);
        exp_t x;
        x.cyc = c; x.val = v; x.name = n;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    // Hold rst over two edges, release 1 ns after an edge; that edge is cyc 0
    task automatic do_reset();
        rst = 1'b1;
        restart = 1'b0;
        repeat (2) @(posedge refclk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        pll_locked = 1'b0;
        do_reset();
        total++;
        if (obs() !== 16'hC000) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", obs(), 16'hC000);
        end
    endtask

    // Lock sampled at edge 10 -> STABLE at 12 -> RUN at 20
    task automatic test_lock_up();
        pll_locked = 1'b0;
        do_reset();
        push(3,  16'hC000, "t1_rst_pulse");
        push(4,  16'h4000, "t1_wait_lock");
        push(19, 16'h4000, "t1_stable_last");
        push(20, 16'h2000, "t1_run");
        repeat (20) begin
            step();
            if (cyc == 9) pll_locked = 1'b1;
            while (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                total++;
                if (obs() !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, obs(), e.val);
                end
            end
        end
    endtask

    // No lock: three attempts, fault at 72, then restart clears it
    task automatic test_fault_restart();
        pll_locked = 1'b0;
        do_reset();
        push(23, 16'h4000, "t2_wait0_end");
        push(24, 16'hC100, "t2_retry1_pulse");
        push(27, 16'hC100, "t2_retry1_pulse_end");
        push(28, 16'h4100, "t2_wait1");
        push(48, 16'hC200, "t2_retry2_pulse");
        push(52, 16'h4200, "t2_wait2");
        push(71, 16'h4200, "t2_wait2_end");
        push(72, 16'hD200, "t2_fault");
        push(80, 16'hD200, "t2_fault_held");
        push(81, 16'hC000, "t2_restart");
        push(84, 16'hC000, "t2_restart_pulse_end");
        push(85, 16'h4000, "t2_restart_wait");
        repeat (85) begin
            step();
            if (cyc == 80) restart = 1'b1;
            if (cyc == 81) restart = 1'b0;
            while (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                total++;
                if (obs() !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, obs(), e.val);
                end
            end
        end
    endtask

    // Lock drop in RUN for 3 samples (edges 25..27) -> re-sequence -> RUN at 40
    task automatic test_lock_loss();
        pll_locked = 1'b0;
        do_reset();
        push(20, 16'h2000, "t3_run");
        push(26, 16'h2000, "t3_run_before_loss");
        push(27, 16'hC001, "t3_loss");
        push(30, 16'hC001, "t3_pulse_end");
        push(31, 16'h4001, "t3_wait");
        push(39, 16'h4001, "t3_stable_last");
        push(40, 16'h2001, "t3_run_again");
        repeat (40) begin
            step();
            if (cyc == 9)  pll_locked = 1'b1;
            if (cyc == 24) pll_locked = 1'b0;
            if (cyc == 27) pll_locked = 1'b1;
            while (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                total++;
                if (obs() !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, obs(), e.val);
                end
            end
        end
    endtask

    // Lock low at edges 18,19 hits STABLE cnt=7 at edge 20; restored at 20 -> RUN at 30
    task automatic test_stable_glitch();
        pll_locked = 1'b0;
        do_reset();
        push(20, 16'h4000, "t4_no_run_at_20");
        push(29, 16'h4000, "t4_stable_last");
        push(30, 16'h2000, "t4_run");
        repeat (30) begin
            step();
            if (cyc == 9)  pll_locked = 1'b1;
            if (cyc == 17) pll_locked = 1'b0;
            if (cyc == 19) pll_locked = 1'b1;
            while (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                total++;
                if (obs() !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, obs(), e.val);
                end
            end
        end
    endtask

    // restart coincides with the final-attempt timeout at edge 72
    task automatic test_restart_priority();
        pll_locked = 1'b0;
        do_reset();
        push(71, 16'h4200, "t5_final_wait");
        push(72, 16'hC000, "t5_restart_wins");
        push(75, 16'hC000, "t5_pulse_end");
        push(76, 16'h4000, "t5_wait");
        repeat (76) begin
            step();
            if (cyc == 71) restart = 1'b1;
            if (cyc == 72) restart = 1'b0;
            while (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                total++;
                if (obs() !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, obs(), e.val);
                end
            end
        end
    endtask

    // 260 lock losses saturate the counter; then async rst mid-STABLE
    task automatic test_saturate_async_rst();
        int          d;
        logic [7:0]  llc;
        pll_locked = 1'b1;
        do_reset();
        push(13, 16'h2000, "t6_first_run");
        repeat (13) begin
            step();
            while (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                total++;
                if (obs() !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, obs(), e.val);
                end
            end
        end
        for (int i = 0; i < 260; i++) begin
            d = cyc;
            llc = (i >= 254) ? 8'd255 : 8'(i + 1);
            pll_locked = 1'b0;
            push(d + 3,  {8'hC0, llc}, "t6_loss");
            push(d + 16, {8'h20, llc}, "t6_run");
            repeat (16) begin
                step();
                if (cyc == d + 3) pll_locked = 1'b1;
                while (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    total++;
                    if (obs() !== e.val) begin
                        bad++;
                        $display("FAIL %s iter=%0d cyc=%0d got=%h exp=%h",
                                 e.name, i, cyc, obs(), e.val);
                    end
                end
            end
        end
        // One more loss, re-lock, and stop partway through STABLE
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        repeat (6) step();
        #5;
        rst = 1'b1;
        #1;
        total++;
        if (obs() !== 16'hC000) begin
            bad++;
            $display("FAIL t6_async_rst got=%h exp=%h", obs(), 16'hC000);
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_fault_restart();
        test_lock_loss();
        test_stable_glitch();
        test_restart_priority();
        test_saturate_async_rst();
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s never_reached cyc=%0d", e.name, e.cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
